eth_rx_mac_filter: RTL and testbench
====================================

Name: eth_rx_mac_filter

Overview:
Destination-address filter on the external RX FIFO loop, rx_clk domain. Consumes the MAC receive stream (ext_rx_fifo_out_*, no backpressure) and feeds the RX async FIFO input (ext_rx_fifo_in_*, with tready). Forwards frames addressed to the local MAC, broadcast, multicast (each enable-gated) or all frames when promiscuous; drops everything else whole. Absorbs short downstream stalls in an internal commit/rewind buffer.

Parameters:
BUF_ADDR_WIDTH, 5, log2 of internal buffer depth (32 entries); must be >= 3
HDR_LEN, 6, destination-address length in bytes; fixed, not overridable per instance

Ports:
clk  in  1  rx_clk domain clock
rst_n  in  1  async assert, active-low reset
s_axis_tdata  in  8  MAC RX byte
s_axis_tvalid  in  1  byte valid; no tready, a valid beat is never stalled
s_axis_tlast  in  1  last byte of frame
s_axis_tuser  in  1  bad-frame flag from MAC
m_axis_tdata  out  8  filtered byte to RX FIFO
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  RX FIFO ready
m_axis_tlast  out  1  last byte
m_axis_tuser  out  1  bad-frame flag
local_mac  in  48  station address; local_mac[47:40] is the first byte on the wire
promisc  in  1  pass all frames of length >= HDR_LEN
bcast_en  in  1  pass FF:FF:FF:FF:FF:FF
mcast_en  in  1  pass when bit 0 of first byte is 1, broadcast excluded
status_drop_filter  out  1  1-cycle pulse: frame dropped on address
status_drop_runt  out  1  1-cycle pulse: frame ended before HDR_LEN bytes
status_overflow  out  1  1-cycle pulse: buffer full on a valid input beat

Behaviour:
- Reset: buffer empty, state HDR, all outputs 0. The MAC shares this reset, so no mid-frame entry occurs.
- Buffer: 2^BUF_ADDR_WIDTH entries of {tdata, tlast, tuser}; pointers wr, rd, commit, start. m_axis_tvalid = (rd != commit). A beat transfers on tvalid && tready. Output holds stable while tready is low.
- Every accepted input beat writes at wr, then wr+1. In PASS, commit follows wr, so a byte written in cycle N is visible on m_axis in cycle N+1.
- HDR: bytes 0..5 are written to the buffer; commit stays at start and the byte count increments.
  - Byte 5 triggers the decision: match = promisc | (dest==local_mac) | (bcast_en & dest==all-ones) | (mcast_en & dest[40] & dest!=all-ones).
  - Match: commit <= wr+1 and go to PASS. If tlast is also set on byte 5, return to HDR with start <= wr+1.
  - No match: wr <= start, pulse status_drop_filter, go to DROP; if tlast, go to HDR instead.
  - tlast before byte 5: wr <= start, pulse status_drop_runt, stay in HDR.
- PASS: forward bytes. On tlast, go to HDR with start <= wr+1. Input tuser passes through unchanged; downstream drops bad frames.
- DROP: discard beats until tlast, then go to HDR.
- Full (wr+1 == rd) with a valid input beat: pulse status_overflow.
  - In HDR: rewind wr <= start, go to DROP, or to HDR if the beat carries tlast.
  - In PASS: discard the beat, go to TRUNC and record whether this beat had tlast.
- TRUNC: discard input beats and keep tracking tlast. When a slot frees, write {0x00, tlast=1, tuser=1}, commit it, and set start after it. Next state is HDR if the input tlast was already seen, else DROP.
- Simultaneous read and write while full: the write is not accepted that cycle (full evaluated on registered pointers).
- Pointers are BUF_ADDR_WIDTH+1 bits wide and wrap naturally; full/empty use the MSB-differs compare.

Decomposition:
- Package eth_rx_filter_pkg holds: state enum {HDR, PASS, DROP, TRUNC}, HDR_LEN=6, BCAST_MAC=48'hFFFF_FFFF_FFFF.
- Sub-module eth_rx_filter_buf is the commit/rewind buffer (write, commit, rewind, read port, full/empty).
- The top level holds the FSM, header capture and compare.

Test Plan:
- local_mac=02:00:00:00:00:01, 64-byte frame to that address, tready=1 -> 64 bytes out unchanged, first byte out 1 cycle after 6th input byte, tlast on byte 64.
- Frame to 02:00:00:00:00:02, promisc=0 -> no m_axis beats, status_drop_filter pulses once in the cycle after input byte 6.
- Broadcast frame with bcast_en=0, then bcast_en=1 -> first dropped, second passed; multicast 01:00:5E:00:00:01 passes only when mcast_en=1.
- 4-byte frame (tlast on byte 3) -> no output, status_drop_runt one pulse, next frame passes intact.
- tready held 0 through a 100-byte matching frame, BUF_ADDR_WIDTH=5 -> status_overflow pulses once; after tready=1, 31 bytes out then terminator 0x00 with tlast=1, tuser=1.
- Back-to-back pass/drop/pass frames with random tready and input tuser=1 on frame 3 -> frames 1 and 3 exact, frame 3 last beat has tuser=1.

Source files
------------

// File: rtl/eth_rx_filter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_rx_filter_pkg : shared types and address-match rule for the RX MAC filter
// Rev 1.0
// ----------------------------------------------------------------------------
package eth_rx_filter_pkg;

  localparam int          HDR_LEN   = 6;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2,
    TRUNC = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  // Multicast excludes broadcast so bcast_en alone governs the all-ones address.
  function automatic logic addr_match(input logic [47:0] dest,
                                      input logic [47:0] station,
                                      input logic        promisc,
                                      input logic        bcast_en,
                                      input logic        mcast_en);
    logic is_bcast;
    is_bcast = (dest == BCAST_MAC);
    return promisc | (dest == station) | (bcast_en & is_bcast) |
           (mcast_en & dest[40] & ~is_bcast);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rx_mac_filter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_rx_mac_filter_if : byte-wide AXI-stream bundle with master/slave views
// Rev 1.0
// ----------------------------------------------------------------------------
interface eth_rx_mac_filter_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface
`default_nettype wire

// File: rtl/eth_rx_filter_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_rx_filter_buf : commit/rewind buffer; only committed entries are readable
// Rev 1.0
// ----------------------------------------------------------------------------
module eth_rx_filter_buf
  import eth_rx_filter_pkg::*;
#(
  parameter int BUF_ADDR_WIDTH = 5
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  input  wire logic  push,
  input  wire beat_t wbeat,
  input  wire logic  commit_en,
  input  wire logic  start_en,
  input  wire logic  rewind,
  output logic       full,
  output logic       rd_valid,
  output beat_t      rd_beat,
  input  wire logic  rd_ready
);

  localparam int DEPTH = 1 << BUF_ADDR_WIDTH;

  typedef logic [BUF_ADDR_WIDTH:0] ptr_t;

  ptr_t  wr_q, rd_q, commit_q, start_q;
  ptr_t  wr_nxt;
  logic  pop;
  beat_t mem [DEPTH];

  assign wr_nxt   = wr_q + ptr_t'(push);
  // One slot is kept free: full when the slot after wr would collide with rd.
  assign full     = ((wr_q + ptr_t'(1)) ^ rd_q) == (ptr_t'(1) << BUF_ADDR_WIDTH);
  assign rd_valid = (rd_q != commit_q);
  assign pop      = rd_valid & rd_ready;
  assign rd_beat  = rd_valid ? mem[rd_q[BUF_ADDR_WIDTH-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      commit_q <= '0;
      start_q  <= '0;
    end else begin
      wr_q <= rewind ? start_q : wr_nxt;
      if (commit_en) commit_q <= wr_nxt;
      if (start_en)  start_q  <= wr_nxt;
      if (pop)       rd_q     <= rd_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[BUF_ADDR_WIDTH-1:0]] <= wbeat;
  end

endmodule
`default_nettype wire

// File: rtl/eth_rx_mac_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_rx_mac_filter : RX destination-address filter with stall-absorbing buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module eth_rx_mac_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int BUF_ADDR_WIDTH = 5
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  eth_rx_mac_filter_if.slave  s_axis,
  eth_rx_mac_filter_if.master m_axis,
  input  wire logic [47:0] local_mac,
  input  wire logic        promisc,
  input  wire logic        bcast_en,
  input  wire logic        mcast_en,
  output logic             status_drop_filter,
  output logic             status_drop_runt,
  output logic             status_overflow
);

  localparam logic [2:0] LAST_HDR = 3'(HDR_LEN - 1);

  state_t      state_q, state_nxt;
  logic [2:0]  cnt_q, cnt_nxt;
  logic [39:0] hdr_q;
  logic        trunc_last_q, trunc_last_nxt;
  logic        hdr_shift, seen_last;
  logic        drop_filter_nxt, drop_runt_nxt, overflow_nxt;

  logic        push, commit_en, start_en, rewind, full, rd_valid;
  beat_t       wbeat, rd_beat;
  logic        match;

  assign s_axis.tready = 1'b1;
  assign match = addr_match({hdr_q, s_axis.tdata}, local_mac, promisc, bcast_en, mcast_en);

  eth_rx_filter_buf #(.BUF_ADDR_WIDTH(BUF_ADDR_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wbeat     (wbeat),
    .commit_en (commit_en),
    .start_en  (start_en),
    .rewind    (rewind),
    .full      (full),
    .rd_valid  (rd_valid),
    .rd_beat   (rd_beat),
    .rd_ready  (m_axis.tready)
  );

  assign m_axis.tvalid = rd_valid;
  assign m_axis.tdata  = rd_beat.data;
  assign m_axis.tlast  = rd_beat.last;
  assign m_axis.tuser  = rd_beat.user;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= HDR;
      cnt_q              <= '0;
      hdr_q              <= '0;
      trunc_last_q       <= 1'b0;
      status_drop_filter <= 1'b0;
      status_drop_runt   <= 1'b0;
      status_overflow    <= 1'b0;
    end else begin
      state_q            <= state_nxt;
      cnt_q              <= cnt_nxt;
      trunc_last_q       <= trunc_last_nxt;
      status_drop_filter <= drop_filter_nxt;
      status_drop_runt   <= drop_runt_nxt;
      status_overflow    <= overflow_nxt;
      if (hdr_shift) hdr_q <= {hdr_q[31:0], s_axis.tdata};
    end
  end

  always_comb begin
    state_nxt       = state_q;
    cnt_nxt         = cnt_q;
    trunc_last_nxt  = trunc_last_q;
    hdr_shift       = 1'b0;
    push            = 1'b0;
    commit_en       = 1'b0;
    start_en        = 1'b0;
    rewind          = 1'b0;
    drop_filter_nxt = 1'b0;
    drop_runt_nxt   = 1'b0;
    overflow_nxt    = 1'b0;
    seen_last       = trunc_last_q | (s_axis.tvalid & s_axis.tlast);
    wbeat           = '{data: s_axis.tdata, last: s_axis.tlast, user: s_axis.tuser};

    unique case (state_q)
      HDR: begin
        if (s_axis.tvalid) begin
          if (full) begin
            overflow_nxt = 1'b1;
            rewind       = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = s_axis.tlast ? HDR : DROP;
          end else begin
            push = 1'b1;
            if (cnt_q == LAST_HDR) begin
              cnt_nxt = '0;
              if (match) begin
                commit_en = 1'b1;
                if (s_axis.tlast) start_en  = 1'b1;
                else              state_nxt = PASS;
              end else begin
                rewind          = 1'b1;
                drop_filter_nxt = 1'b1;
                state_nxt       = s_axis.tlast ? HDR : DROP;
              end
            end else if (s_axis.tlast) begin
              rewind        = 1'b1;
              drop_runt_nxt = 1'b1;
              cnt_nxt       = '0;
            end else begin
              hdr_shift = 1'b1;
              cnt_nxt   = cnt_q + 3'd1;
            end
          end
        end
      end
      PASS: begin
        if (s_axis.tvalid) begin
          if (full) begin
            overflow_nxt   = 1'b1;
            trunc_last_nxt = s_axis.tlast;
            state_nxt      = TRUNC;
          end else begin
            push      = 1'b1;
            commit_en = 1'b1;
            if (s_axis.tlast) begin
              start_en  = 1'b1;
              state_nxt = HDR;
            end
          end
        end
      end
      DROP: begin
        if (s_axis.tvalid && s_axis.tlast) state_nxt = HDR;
      end
      TRUNC: begin
        trunc_last_nxt = seen_last;
        // Close the truncated frame with a bad-frame terminator once a slot frees.
        if (!full) begin
          push           = 1'b1;
          wbeat          = '{data: 8'h00, last: 1'b1, user: 1'b1};
          commit_en      = 1'b1;
          start_en       = 1'b1;
          trunc_last_nxt = 1'b0;
          state_nxt      = seen_last ? HDR : DROP;
        end
      end
      default: state_nxt = HDR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_mac_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_eth_rx_mac_filter : scoreboard bench with a frame-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_eth_rx_mac_filter;

  localparam int R_PASS   = 0;
  localparam int R_FILTER = 1;
  localparam int R_RUNT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_rx_mac_filter_if s_if ();
  eth_rx_mac_filter_if m_if ();

  logic [47:0] local_mac;
  logic        promisc, bcast_en, mcast_en;
  logic        st_filter, st_runt, st_ovf;

  eth_rx_mac_filter #(.BUF_ADDR_WIDTH(5)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis             (s_if),
    .m_axis             (m_if),
    .local_mac          (local_mac),
    .promisc            (promisc),
    .bcast_en           (bcast_en),
    .mcast_en           (mcast_en),
    .status_drop_filter (st_filter),
    .status_drop_runt   (st_runt),
    .status_overflow    (st_ovf)
  );

  int checks = 0, errors = 0;
  logic [9:0] expq [$];
  logic [7:0] frm [$];
  int n_sent = 0, n_popped = 0;
  int exp_filter = 0, exp_runt = 0, exp_ovf = 0;
  int got_filter = 0, got_runt = 0, got_ovf = 0;
  int ready_mode = 1;   // 0 low, 1 high, 2 random
  logic throttle_dead = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sole driver of the downstream ready.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_if.tready = (ready_mode == 2) ? ($urandom_range(3) != 0) : (ready_mode == 1);
    end
  end

  // Monitor: pop-and-compare on every handshake, hold check, status pulse counting.
  initial begin
    logic       prev_stall;
    logic [9:0] prev_beat, cur;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cur = {m_if.tdata, m_if.tlast, m_if.tuser};
        if (prev_stall) check("hold_stable", {m_if.tvalid, cur}, {1'b1, prev_beat});
        if (m_if.tvalid && m_if.tready) begin
          n_popped++;
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat actual=%0h expected=none", cur);
          end else begin
            check("beat", cur, expq.pop_front());
          end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_beat  = cur;
        if (st_filter) got_filter++;
        if (st_runt)   got_runt++;
        if (st_ovf)    got_ovf++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_beat(input logic [7:0] d, input logic l, input logic u);
    @(posedge clk); #1;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = l; s_if.tuser = u;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
  endtask

  task automatic build_frame(input logic [47:0] dest, input int len);
    frm.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) frm.push_back(dest[47-8*i -: 8]);
      else       frm.push_back(8'($urandom_range(255)));
    end
  endtask

  // Reference decision from the frame contents and current filter settings.
  function automatic int classify();
    logic [47:0] dest;
    logic [7:0]  b0;
    logic        is_bcast;
    if (frm.size() < 6) return R_RUNT;
    dest = '0;
    for (int i = 0; i < 6; i++) dest = {dest[39:0], frm[i]};
    b0 = frm[0];
    is_bcast = (dest == 48'hFFFF_FFFF_FFFF);
    if (promisc || dest == local_mac || (bcast_en && is_bcast) || (mcast_en && b0[0] && !is_bcast))
      return R_PASS;
    return R_FILTER;
  endfunction

  // tcheck: 0 none, 1 first-output latency, 2 filter-pulse timing.
  task automatic send_frame(input logic user_last, input int gap_pct, input int tcheck);
    int res, n, guard;
    logic last;
    res = classify();
    n = frm.size();
    if (res == R_PASS)
      for (int i = 0; i < n; i++) expq.push_back({frm[i], i == n-1, (i == n-1) & user_last});
    else if (res == R_FILTER) exp_filter++;
    else exp_runt++;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!throttle_dead && (n_sent - n_popped) > 20) begin
        idle_cycle();
        guard++;
        if (guard > 3000) begin
          throttle_dead = 1'b1;
          checks++; errors++;
          $display("FAIL throttle_timeout actual=%0d expected<=20", n_sent - n_popped);
        end
      end
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle_cycle();
      last = (i == n-1);
      drive_beat(frm[i], last, last & user_last);
      if (res == R_PASS) n_sent++;
      if (tcheck == 1 && i == 5) begin
        @(negedge clk);
        check("hdr_not_visible", m_if.tvalid, 0);
      end
      if (tcheck != 0 && i == 6) begin
        @(negedge clk);
        if (tcheck == 1) begin
          check("first_out_valid", m_if.tvalid, 1);
          check("first_out_data", m_if.tdata, frm[0]);
        end else begin
          check("filter_pulse_timing", st_filter, 1);
        end
      end
    end
    idle_cycle();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check(name, expq.size(), 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_filter_cnt"}, got_filter, exp_filter);
    check({tag, "_runt_cnt"}, got_runt, exp_runt);
    check({tag, "_ovf_cnt"}, got_ovf, exp_ovf);
  endtask

  initial begin
    logic [47:0] d;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    local_mac = 48'h02_00_00_00_00_01;
    promisc = 1'b0; bcast_en = 1'b0; mcast_en = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tdata", {m_if.tdata, m_if.tlast, m_if.tuser}, 0);
    check("rst_status", {st_filter, st_runt, st_ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) idle_cycle();

    // Matching 64-byte frame, latency check
    build_frame(48'h02_00_00_00_00_01, 64);
    send_frame(1'b0, 0, 1);
    wait_drain("drain_unicast");

    // Foreign unicast dropped, pulse timing
    build_frame(48'h02_00_00_00_00_02, 20);
    send_frame(1'b0, 0, 2);

    // Broadcast and multicast enables
    build_frame(48'hFFFF_FFFF_FFFF, 12); send_frame(1'b0, 0, 0);
    bcast_en = 1'b1;
    build_frame(48'hFFFF_FFFF_FFFF, 12); send_frame(1'b0, 0, 0);
    bcast_en = 1'b0;
    build_frame(48'h01_00_5E_00_00_01, 10); send_frame(1'b0, 0, 0);
    mcast_en = 1'b1;
    build_frame(48'h01_00_5E_00_00_01, 10); send_frame(1'b0, 0, 0);
    mcast_en = 1'b0;

    // Runts, then frames at and above the header boundary
    build_frame(48'h02_00_00_00_00_01, 4); send_frame(1'b0, 0, 0);
    build_frame(48'h02_00_00_00_00_01, 5); send_frame(1'b0, 0, 0);
    build_frame(48'h02_00_00_00_00_01, 10); send_frame(1'b0, 0, 0);
    build_frame(48'h02_00_00_00_00_01, 6); send_frame(1'b0, 0, 0);
    wait_drain("drain_directed");
    check_status("directed");

    // Overflow: downstream stalled through a 100-byte matching frame
    ready_mode = 0;
    repeat (2) idle_cycle();
    build_frame(48'h02_00_00_00_00_01, 100);
    for (int i = 0; i < 31; i++) expq.push_back({frm[i], 1'b0, 1'b0});
    expq.push_back({8'h00, 1'b1, 1'b1});
    exp_ovf++;
    n_sent += 32;
    for (int i = 0; i < 100; i++) drive_beat(frm[i], i == 99, 1'b0);
    repeat (5) idle_cycle();
    @(negedge clk);
    check("ovf_stalled_valid", m_if.tvalid, 1);
    ready_mode = 1;
    wait_drain("drain_overflow");
    check_status("overflow");

    // Back-to-back pass/drop/pass with random ready, bad-frame flag on frame 3
    ready_mode = 2;
    build_frame(48'h02_00_00_00_00_01, 20); send_frame(1'b0, 0, 0);
    build_frame(48'h02_00_00_00_00_02, 15); send_frame(1'b0, 0, 0);
    build_frame(48'h02_00_00_00_00_01, 25); send_frame(1'b1, 0, 0);

    // Random frames with random settings
    for (int f = 0; f < 40; f++) begin
      promisc  = ($urandom_range(7) == 0);
      bcast_en = $urandom_range(1);
      mcast_en = $urandom_range(1);
      case ($urandom_range(3))
        0:       d = local_mac;
        1:       d = 48'h02_00_00_00_00_02;
        2:       d = 48'hFFFF_FFFF_FFFF;
        default: d = {40'h01_00_5E_00_00, 8'($urandom_range(255))};
      endcase
      build_frame(d, $urandom_range(30, 1));
      send_frame($urandom_range(1), 20, 0);
    end
    ready_mode = 1;
    wait_drain("drain_random");
    check_status("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
